// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key press classifier.
package key_pkg;

   typedef enum logic [1:0] {
      KEY_IDLE,
      KEY_PRESSED,
      KEY_LONG
   } key_state_t;

   // Defaults assume a 50 MHz FPGA_clk.
   localparam int KEY_DEBOUNCE_CYC = 1_000_000;
   localparam int KEY_LONG_CYC     = 11_111_111;
   localparam int KEY_REPEAT_CYC   = 5_000_000;
   localparam int KEY_CNT_W        = 25;

endpackage

// File: rtl/key_sync_debounce.sv
// Two-flop synchroniser for the raw active-low key followed by a stable-count debouncer.
module key_sync_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
   parameter int CNT_W        = KEY_CNT_W
) (
   input  logic FPGA_clk,
   input  logic FPGA_rst,
   input  logic key_raw,
   output logic key_clean
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             s1_reg;
   logic             s2_reg;
   logic             key_clean_reg;
   logic [CNT_W-1:0] db_cnt_reg;

   always_ff @(posedge FPGA_clk) begin
      if (FPGA_rst) begin
         s1_reg        <= 1'b1;
         s2_reg        <= 1'b1;
         key_clean_reg <= 1'b1;
         db_cnt_reg    <= '0;
      end else begin
         s1_reg <= key_raw;
         s2_reg <= s1_reg;
         // Any cycle of agreement restarts the count, so short glitches never land.
         if (s2_reg == key_clean_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DB_LAST) begin
            key_clean_reg <= s2_reg;
            db_cnt_reg    <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign key_clean = key_clean_reg;

endmodule

// File: rtl/key_press_classifier.sv
// Debounced key with short/long press classification; define KEY_REPEAT_EN to add
// periodic repeat pulses while a long press is held.
module key_press_classifier
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
   parameter int LONG_CYC     = KEY_LONG_CYC,
   parameter int REPEAT_CYC   = KEY_REPEAT_CYC,
   parameter int CNT_W        = KEY_CNT_W
) (
   input  logic FPGA_clk,
   input  logic FPGA_rst,
   input  logic KEY1,
   output logic key_clean,
   output logic key_held,
   output logic long_flag,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

   key_state_t       state_reg;
   logic [CNT_W-1:0] hold_cnt_reg;
   logic             key_clean_d_reg;
   logic             key_held_reg;
   logic             long_flag_reg;
   logic             short_pulse_reg;
   logic             long_pulse_reg;
   logic             key_fall;

   key_sync_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_sync_debounce (
      .FPGA_clk  (FPGA_clk),
      .FPGA_rst  (FPGA_rst),
      .key_raw   (KEY1),
      .key_clean (key_clean)
   );

   assign key_fall = key_clean_d_reg & ~key_clean;

   always_ff @(posedge FPGA_clk) begin
      if (FPGA_rst) begin
         state_reg       <= KEY_IDLE;
         hold_cnt_reg    <= '0;
         key_clean_d_reg <= 1'b1;
         key_held_reg    <= 1'b0;
         long_flag_reg   <= 1'b0;
         short_pulse_reg <= 1'b0;
         long_pulse_reg  <= 1'b0;
      end else begin
         key_clean_d_reg <= key_clean;
         short_pulse_reg <= 1'b0;
         long_pulse_reg  <= 1'b0;
         case (state_reg)
            KEY_IDLE: begin
               if (key_fall) begin
                  state_reg    <= KEY_PRESSED;
                  hold_cnt_reg <= '0;
                  key_held_reg <= 1'b1;
               end
            end
            KEY_PRESSED: begin
               // Release is tested first so it wins over a coinciding long threshold.
               if (key_clean) begin
                  state_reg       <= KEY_IDLE;
                  key_held_reg    <= 1'b0;
                  short_pulse_reg <= 1'b1;
               end else if (hold_cnt_reg == LONG_LAST) begin
                  state_reg      <= KEY_LONG;
                  long_flag_reg  <= 1'b1;
                  long_pulse_reg <= 1'b1;
               end else if (hold_cnt_reg != '1) begin
                  hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
               end
            end
            KEY_LONG: begin
               if (key_clean) begin
                  state_reg     <= KEY_IDLE;
                  key_held_reg  <= 1'b0;
                  long_flag_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= KEY_IDLE;
               key_held_reg  <= 1'b0;
               long_flag_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

   logic [CNT_W-1:0] rep_cnt_reg;
   logic             repeat_pulse_reg;

   // rep_cnt is zero on the long_pulse edge, so the first repeat lands REPEAT_CYC later.
   always_ff @(posedge FPGA_clk) begin
      if (FPGA_rst) begin
         rep_cnt_reg      <= '0;
         repeat_pulse_reg <= 1'b0;
      end else begin
         repeat_pulse_reg <= 1'b0;
         if (state_reg == KEY_LONG && !key_clean) begin
            if (rep_cnt_reg == REP_LAST) begin
               rep_cnt_reg      <= '0;
               repeat_pulse_reg <= 1'b1;
            end else begin
               rep_cnt_reg <= rep_cnt_reg + CNT_W'(1);
            end
         end else begin
            rep_cnt_reg <= '0;
         end
      end
   end

   assign repeat_pulse = repeat_pulse_reg;
`else
   // Always false since REPEAT_CYC >= 1; keeps the parameter referenced in this build.
   assign repeat_pulse = (REPEAT_CYC < 0);
`endif

   assign key_held    = key_held_reg;
   assign long_flag   = long_flag_reg;
   assign short_pulse = short_pulse_reg;
   assign long_pulse  = long_pulse_reg;

endmodule

// File: tb/tb_key_press_classifier.sv
// Scoreboard bench for key_press_classifier with DEBOUNCE_CYC=4, LONG_CYC=10, REPEAT_CYC=3.
module tb_key_press_classifier;

   localparam int DB  = 4;
   localparam int LNG = 10;
   localparam int REP = 3;

   typedef struct {
      int kind;   // 0 short, 1 long, 2 repeat
      int cyc;
   } ev_t;

   logic FPGA_clk = 1'b0;
   logic FPGA_rst = 1'b1;
   logic KEY1     = 1'b1;
   logic key_clean, key_held, long_flag, short_pulse, long_pulse, repeat_pulse;

   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;
   ev_t  exp_q[$];
   string kname[3] = '{"short", "long", "repeat"};

   key_press_classifier #(
      .DEBOUNCE_CYC (DB),
      .LONG_CYC     (LNG),
      .REPEAT_CYC   (REP)
   ) dut (
      .FPGA_clk     (FPGA_clk),
      .FPGA_rst     (FPGA_rst),
      .KEY1         (KEY1),
      .key_clean    (key_clean),
      .key_held     (key_held),
      .long_flag    (long_flag),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse)
   );

   always #5 FPGA_clk = ~FPGA_clk;

   // cyc holds the index of the most recent rising edge.
   always @(posedge FPGA_clk) cyc <= cyc + 1;

   // Scoreboard: every pulse seen is matched against the head of the expectation queue.
   always @(negedge FPGA_clk) begin
      int   n_hi;
      int   k;
      ev_t  ev;
      n_hi = int'(short_pulse) + int'(long_pulse) + int'(repeat_pulse);
      if (n_hi > 0) begin
         k = short_pulse ? 0 : (long_pulse ? 1 : 2);
         $display("[TB] cyc %0d %s_pulse observed", cyc, kname[k]);
         tests_run++;
         if (n_hi > 1) begin
            tests_failed++;
            $display("FAIL pulse_exclusive cyc %0d: %0d pulses high, required at most 1", cyc, n_hi);
         end else if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_pulse cyc %0d: got %s, required none", cyc, kname[k]);
         end else begin
            ev = exp_q.pop_front();
            if (ev.kind !== k || ev.cyc !== cyc) begin
               tests_failed++;
               $display("FAIL pulse_match: got %s at cyc %0d, required %s at cyc %0d",
                        kname[k], cyc, kname[ev.kind], ev.cyc);
            end
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge FPGA_clk);
   endtask

   task automatic push_ev(input int kind, input int c);
      ev_t ev;
      ev.kind = kind;
      ev.cyc  = c;
      exp_q.push_back(ev);
   endtask

   task automatic test_reset();
      FPGA_rst = 1'b1;
      KEY1     = 1'b1;
      repeat (3) @(negedge FPGA_clk);
      tests_run += 6;
      if (key_clean !== 1'b1) begin tests_failed++; $display("FAIL reset_key_clean: got %b, required 1", key_clean); end
      if (key_held !== 1'b0) begin tests_failed++; $display("FAIL reset_key_held: got %b, required 0", key_held); end
      if (long_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_long_flag: got %b, required 0", long_flag); end
      if (short_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_short_pulse: got %b, required 0", short_pulse); end
      if (long_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_long_pulse: got %b, required 0", long_pulse); end
      if (repeat_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_repeat_pulse: got %b, required 0", repeat_pulse); end
      FPGA_rst = 1'b0;
      repeat (2) @(negedge FPGA_clk);
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 20; i++) begin
         KEY1 = i[0];
         @(negedge FPGA_clk);
         tests_run++;
         if (key_clean !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_key_clean cyc %0d: got %b, required 1", cyc, key_clean);
         end
      end
      KEY1 = 1'b1;
      repeat (8) @(negedge FPGA_clk);
      tests_run += 2;
      if (key_clean !== 1'b1) begin tests_failed++; $display("FAIL glitch_settle_clean: got %b, required 1", key_clean); end
      if (key_held !== 1'b0) begin tests_failed++; $display("FAIL glitch_key_held: got %b, required 0", key_held); end
      tests_run++;
      if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL glitch_drain: %0d pulses missing, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   // KEY1 low for 8 raw cycles: key_clean low n+5..n+12, short_pulse at n+14.
   task automatic test_short_press();
      int n;
      KEY1 = 1'b0;
      n = cyc + 1;
      push_ev(0, n + 14);
      wait_until(n + 4);
      tests_run++;
      if (key_clean !== 1'b1) begin tests_failed++; $display("FAIL short_clean_early: got %b, required 1", key_clean); end
      wait_until(n + 5);
      tests_run++;
      if (key_clean !== 1'b0) begin tests_failed++; $display("FAIL short_clean_fall: got %b, required 0", key_clean); end
      wait_until(n + 6);
      tests_run++;
      if (key_held !== 1'b1) begin tests_failed++; $display("FAIL short_held_rise: got %b, required 1", key_held); end
      wait_until(n + 7);
      KEY1 = 1'b1;
      wait_until(n + 13);
      tests_run++;
      if (key_clean !== 1'b1) begin tests_failed++; $display("FAIL short_clean_rise: got %b, required 1", key_clean); end
      wait_until(n + 14);
      tests_run += 2;
      if (key_held !== 1'b0) begin tests_failed++; $display("FAIL short_held_fall: got %b, required 0", key_held); end
      if (long_flag !== 1'b0) begin tests_failed++; $display("FAIL short_long_flag: got %b, required 0", long_flag); end
      wait_until(n + 26);
      tests_run++;
      if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL short_drain: %0d pulses missing, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   // KEY1 low 30 raw cycles: long_pulse at n+16, release seen by the FSM at n+36.
   task automatic test_long_hold();
      int n;
      KEY1 = 1'b0;
      n = cyc + 1;
      push_ev(1, n + 16);
`ifdef KEY_REPEAT_EN
      for (int t = n + 16 + REP; t <= n + 35; t += REP) push_ev(2, t);
`endif
      wait_until(n + 6);
      tests_run++;
      if (key_held !== 1'b1) begin tests_failed++; $display("FAIL long_held_rise: got %b, required 1", key_held); end
      wait_until(n + 15);
      tests_run++;
      if (long_flag !== 1'b0) begin tests_failed++; $display("FAIL long_flag_early: got %b, required 0", long_flag); end
      for (int c = n + 16; c <= n + 35; c++) begin
         wait_until(c);
         if (c == n + 29) KEY1 = 1'b1;
         tests_run++;
         if (long_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL long_flag_hold cyc %0d: got %b, required 1", cyc, long_flag);
         end
      end
      tests_run++;
      if (key_clean !== 1'b1) begin tests_failed++; $display("FAIL long_clean_rise: got %b, required 1", key_clean); end
      wait_until(n + 36);
      tests_run += 2;
      if (long_flag !== 1'b0) begin tests_failed++; $display("FAIL long_flag_release: got %b, required 0", long_flag); end
      if (key_held !== 1'b0) begin tests_failed++; $display("FAIL long_held_release: got %b, required 0", key_held); end
      wait_until(n + 46);
      tests_run++;
      if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL long_drain: %0d pulses missing, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   // Reset sampled at n+9 while PRESSED; key still low so key_clean falls again at n+15.
   task automatic test_reset_mid_press();
      int n;
      KEY1 = 1'b0;
      n = cyc + 1;
      push_ev(0, n + 24);
      wait_until(n + 6);
      tests_run++;
      if (key_held !== 1'b1) begin tests_failed++; $display("FAIL rstmid_held_before: got %b, required 1", key_held); end
      wait_until(n + 8);
      FPGA_rst = 1'b1;
      wait_until(n + 9);
      FPGA_rst = 1'b0;
      tests_run += 3;
      if (key_clean !== 1'b1) begin tests_failed++; $display("FAIL rstmid_clean: got %b, required 1", key_clean); end
      if (key_held !== 1'b0) begin tests_failed++; $display("FAIL rstmid_held: got %b, required 0", key_held); end
      if (long_flag !== 1'b0) begin tests_failed++; $display("FAIL rstmid_long_flag: got %b, required 0", long_flag); end
      wait_until(n + 14);
      tests_run++;
      if (key_clean !== 1'b1) begin tests_failed++; $display("FAIL rstmid_clean_early: got %b, required 1", key_clean); end
      wait_until(n + 15);
      tests_run++;
      if (key_clean !== 1'b0) begin tests_failed++; $display("FAIL rstmid_clean_fall: got %b, required 0", key_clean); end
      wait_until(n + 16);
      tests_run++;
      if (key_held !== 1'b1) begin tests_failed++; $display("FAIL rstmid_held_rise: got %b, required 1", key_held); end
      wait_until(n + 17);
      KEY1 = 1'b1;
      wait_until(n + 36);
      tests_run++;
      if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL rstmid_drain: %0d pulses missing, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   // key_clean returns at n+15, so the FSM sees release with hold_cnt=9 at n+16.
   task automatic test_release_at_threshold();
      int n;
      KEY1 = 1'b0;
      n = cyc + 1;
      push_ev(0, n + 16);
      wait_until(n + 9);
      KEY1 = 1'b1;
      wait_until(n + 15);
      tests_run++;
      if (key_clean !== 1'b1) begin tests_failed++; $display("FAIL coinc_clean_rise: got %b, required 1", key_clean); end
      wait_until(n + 17);
      tests_run += 2;
      if (long_flag !== 1'b0) begin tests_failed++; $display("FAIL coinc_long_flag: got %b, required 0", long_flag); end
      if (key_held !== 1'b0) begin tests_failed++; $display("FAIL coinc_idle: key_held %b, required 0", key_held); end
      wait_until(n + 28);
      tests_run++;
      if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL coinc_drain: %0d pulses missing, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_short_press();
      test_long_hold();
      test_reset_mid_press();
      test_release_at_threshold();
      test_short_press();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish by %0t", $time);
      $fatal(1);
   end

endmodule
